// File: rtl/vdg_pkg.sv
// Shared types and default widths for the video memory arbiter and its address generator.
package vdg_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int BPR_W      = 6;
    localparam int REP_W      = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VID_A = 3'd1,
        VID_D = 3'd2,
        CPU_A = 3'd3,
        CPU_D = 3'd4
    } arb_state_t;

    function automatic logic is_vid_state(arb_state_t s);
        return (s == VID_A) || (s == VID_D);
    endfunction

    function automatic logic is_cpu_state(arb_state_t s);
        return (s == CPU_A) || (s == CPU_D);
    endfunction

endpackage

// File: rtl/video_addr_gen.sv
// Video address counter (VA), row-start register (RS) and line-in-row counter (LC),
// driven by frame/line sync falling edges and the arbiter's fetch-complete strobe.
module video_addr_gen
    import vdg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_fsn,
    input  logic              i_hsn,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [BPR_W-1:0]  i_bytes_per_row,
    input  logic [REP_W-1:0]  i_row_repeat,
    output logic [ADDR_W-1:0] o_va
);

    logic              r_fsn_d;
    logic              r_hsn_d;
    logic [ADDR_W-1:0] r_va;
    logic [ADDR_W-1:0] r_rs;
    logic [REP_W-1:0]  r_lc;

    logic              w_fs_fall;
    logic              w_hs_fall;
    logic [REP_W-1:0]  w_rep_last;
    logic [ADDR_W-1:0] w_rs_adv;

    assign w_fs_fall  = r_fsn_d & ~i_fsn;
    assign w_hs_fall  = r_hsn_d & ~i_hsn;
    // A repeat count of 0 behaves as 1: every line starts a new row.
    assign w_rep_last = (i_row_repeat == '0) ? '0 : i_row_repeat - REP_W'(1);
    assign w_rs_adv   = r_rs + ADDR_W'(i_bytes_per_row);
    assign o_va       = r_va;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_fsn_d <= 1'b1;
            r_hsn_d <= 1'b1;
            r_va    <= '0;
            r_rs    <= '0;
            r_lc    <= '0;
        end else begin
            r_fsn_d <= i_fsn;
            r_hsn_d <= i_hsn;
            if (w_fs_fall) begin
                r_va <= i_start_addr;
                r_rs <= i_start_addr;
                r_lc <= '0;
            end else if (i_fsn) begin
                // A line edge overrides a same-cycle fetch increment.
                if (w_hs_fall) begin
                    if (r_lc < w_rep_last) begin
                        r_lc <= r_lc + REP_W'(1);
                        r_va <= r_rs;
                    end else begin
                        r_lc <= '0;
                        r_rs <= w_rs_adv;
                        r_va <= w_rs_adv;
                    end
                end else if (i_inc) begin
                    r_va <= r_va + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/video_mem_arbiter.sv
// Two-cycle RAM access arbiter between video fetches (priority) and CPU reads/writes.
module video_mem_arbiter
    import vdg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FSn,
    input  logic              HSn,
    input  logic              Load,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [5:0]        BytesPerRow,
    input  logic [3:0]        RowRepeat,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuAck,
    output logic [DATA_W-1:0] CpuRData,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData,
    output logic              RamCe,
    output logic              RamWe,
    output logic [DATA_W-1:0] VidData,
    output logic              VidValid,
    output logic              VidOverrun
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_vid_pend;
    logic              r_overrun;
    logic              r_cpu_we;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [DATA_W-1:0] r_cpu_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_vid_valid;

    logic              w_vid_req;
    logic              w_vid_start;
    logic              w_cpu_start;
    logic [ADDR_W-1:0] w_va;

    video_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk             (Clk),
        .srst            (Reset),
        .i_fsn           (FSn),
        .i_hsn           (HSn),
        .i_inc           (r_state == VID_D),
        .i_start_addr    (StartAddr),
        .i_bytes_per_row (BytesPerRow),
        .i_row_repeat    (RowRepeat),
        .o_va            (w_va)
    );

    // A Load in the same cycle as a decision point is served without waiting for the flag.
    assign w_vid_req = r_vid_pend | Load;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_vid_req)   w_state_next = VID_A;
                else if (CpuReq) w_state_next = CPU_A;
            end
            VID_A:   w_state_next = VID_D;
            VID_D:   w_state_next = w_vid_req ? VID_A : IDLE;
            CPU_A:   w_state_next = CPU_D;
            CPU_D:   w_state_next = w_vid_req ? VID_A : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_vid_start = (w_state_next == VID_A);
    assign w_cpu_start = (r_state == IDLE) && (w_state_next == CPU_A);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_vid_pend  <= 1'b0;
            r_overrun   <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_vid_pend <= w_vid_start ? 1'b0 : w_vid_req;
            // A second Load while one is still queued is dropped and flagged.
            if (Load && r_vid_pend) r_overrun <= 1'b1;
            if (w_cpu_start) begin
                r_cpu_we    <= CpuWe;
                r_cpu_addr  <= CpuAddr;
                r_cpu_wdata <= CpuWData;
            end
            r_vid_valid <= (r_state == VID_D);
            if (r_state == VID_D) r_vid_data <= RamRData;
            r_cpu_ack <= (r_state == CPU_D);
            if (r_state == CPU_D && !r_cpu_we) r_cpu_rdata <= RamRData;
        end
    end

    always_comb begin
        RamAddr  = '0;
        RamWData = '0;
        RamWe    = 1'b0;
        RamCe    = (r_state != IDLE);
        if (is_vid_state(r_state)) begin
            RamAddr = w_va;
        end else if (is_cpu_state(r_state)) begin
            RamAddr = r_cpu_addr;
            RamWe   = r_cpu_we;
            if (r_cpu_we) RamWData = r_cpu_wdata;
        end
    end

    assign CpuAck     = r_cpu_ack;
    assign CpuRData   = r_cpu_rdata;
    assign VidData    = r_vid_data;
    assign VidValid   = r_vid_valid;
    assign VidOverrun = r_overrun;

endmodule
